// File: rtl/jk_bank_arb.sv
// Round-robin arbiter that shares one external jk flip-flop bank between requesters.
// Each granted operation drives j/k for one cycle, then reports the post-update bit with a grant pulse.
module jk_bank_arb #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [IDXW*NREQ-1:0]   req_idx,
  input  logic [NBITS-1:0]       q_in,
  output logic [NBITS-1:0]       j_out,
  output logic [NBITS-1:0]       k_out,
  output logic [NREQ-1:0]        grant,
  output logic                   ack_q,
  output logic                   err,
  output logic                   busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK} state_t;

  state_t            r_state, w_state_next;
  logic [PW-1:0]     r_ptr, w_ptr_next;
  logic [PW-1:0]     r_win, w_win_next;
  logic [1:0]        r_op, w_op_next;
  logic [IDXW-1:0]   r_idx, w_idx_next;
  logic [NBITS-1:0]  r_j, w_j_next;
  logic [NBITS-1:0]  r_k, w_k_next;
  logic [NREQ-1:0]   r_grant, w_grant_next;
  logic              r_ack_q, w_ack_q_next;
  logic              r_err, w_err_next;

  logic              w_any;
  logic [PW-1:0]     w_sel;
  logic [PW-1:0]     w_cand;
  logic [1:0]        w_sel_op;
  logic [IDXW-1:0]   w_sel_idx;
  logic [NBITS-1:0]  w_sel_mask;
  logic [NBITS-1:0]  w_lat_mask;
  logic              w_cur;
  logic              w_oob;

  // Scan from the highest offset down so the first requester at or after the pointer wins.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = r_ptr;
    w_cand = r_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_cand = PW'((int'(r_ptr) + i) % NREQ);
      if (req_valid[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  assign w_sel_op  = req_op[int'(w_sel) * 2 +: 2];
  assign w_sel_idx = req_idx[int'(w_sel) * IDXW +: IDXW];

  // One-hot masks only cover real bank bits, so an out-of-range index yields an all-zero mask.
  for (genvar gi = 0; gi < NBITS; gi++) begin : g_mask
    assign w_sel_mask[gi] = (w_sel_idx == IDXW'(gi));
    assign w_lat_mask[gi] = (r_idx == IDXW'(gi));
  end

  assign w_cur = |(q_in & w_lat_mask);
  assign w_oob = (int'(r_idx) >= NBITS);

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_win_next   = r_win;
    w_op_next    = r_op;
    w_idx_next   = r_idx;
    w_j_next     = '0;
    w_k_next     = '0;
    w_grant_next = '0;
    w_ack_q_next = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_win_next   = w_sel;
          w_op_next    = w_sel_op;
          w_idx_next   = w_sel_idx;
          w_j_next     = w_sel_op[1] ? w_sel_mask : '0;
          w_k_next     = w_sel_op[0] ? w_sel_mask : '0;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The bank captures on this same edge, so the post-update bit is predicted from q_in and op.
        w_grant_next[r_win] = 1'b1;
        w_err_next          = w_oob;
        case (r_op)
          2'b00:   w_ack_q_next = w_cur;
          2'b01:   w_ack_q_next = 1'b0;
          2'b10:   w_ack_q_next = 1'b1;
          default: w_ack_q_next = ~w_cur;
        endcase
        if (w_oob) w_ack_q_next = 1'b0;
        w_state_next = S_ACK;
      end
      S_ACK: begin
        w_ptr_next   = (int'(r_win) == NREQ - 1) ? '0 : r_win + PW'(1);
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_op    <= '0;
      r_idx   <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_grant <= '0;
      r_ack_q <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_win   <= w_win_next;
      r_op    <= w_op_next;
      r_idx   <= w_idx_next;
      r_j     <= w_j_next;
      r_k     <= w_k_next;
      r_grant <= w_grant_next;
      r_ack_q <= w_ack_q_next;
      r_err   <= w_err_next;
    end
  end

  assign j_out = r_j;
  assign k_out = r_k;
  assign grant = r_grant;
  assign ack_q = r_ack_q;
  assign err   = r_err;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_jk_bank_arb.sv
// Scoreboard bench: two arbiters (8-bit and 6-bit bank) each driving a behavioural jk bank.
// Stimulus pushes hand-computed expectations; per-DUT monitors pop them on every grant.
module tb_jk_bank_arb;

  logic clk;
  logic rst;

  logic [3:0]  req_valid_a, req_valid_b;
  logic [7:0]  req_op_a, req_op_b;
  logic [11:0] req_idx_a, req_idx_b;
  logic [7:0]  q_a, j_a, k_a;
  logic [5:0]  q_b, j_b, k_b;
  logic [3:0]  grant_a, grant_b;
  logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] grant;
    logic       ack;
    logic       err;
    logic [7:0] j;
    logic [7:0] k;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  jk_bank_arb #(.NREQ(4), .NBITS(8), .IDXW(3)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_op(req_op_a), .req_idx(req_idx_a),
    .q_in(q_a), .j_out(j_a), .k_out(k_a), .grant(grant_a), .ack_q(ack_a), .err(err_a), .busy(busy_a)
  );

  jk_bank_arb #(.NREQ(4), .NBITS(6), .IDXW(3)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_op(req_op_b), .req_idx(req_idx_b),
    .q_in(q_b), .j_out(j_b), .k_out(k_b), .grant(grant_b), .ack_q(ack_b), .err(err_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural jk banks; they have their own reset (power-up to zero) and ignore rst.
  initial begin
    q_a = '0;
    q_b = '0;
  end
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      case ({j_a[i], k_a[i]})
        2'b10:   q_a[i] <= 1'b1;
        2'b01:   q_a[i] <= 1'b0;
        2'b11:   q_a[i] <= ~q_a[i];
        default: q_a[i] <= q_a[i];
      endcase
    for (int i = 0; i < 6; i++)
      case ({j_b[i], k_b[i]})
        2'b10:   q_b[i] <= 1'b1;
        2'b01:   q_b[i] <= 1'b0;
        2'b11:   q_b[i] <= ~q_b[i];
        default: q_b[i] <= q_b[i];
      endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  // Monitors: ISSUE cycles check j/k against the head entry, grant cycles pop and check.
  always @(negedge clk) begin
    if (grant_a != 4'b0) begin
      if (qa.size() == 0) flag("a_unexpected_grant");
      else begin
        ea = qa.pop_front();
        $display("txn A grant=%b ack_q=%b err=%b cycle=%0d", grant_a, ack_a, err_a, cyc);
        chk("a_grant", 32'(grant_a), 32'(ea.grant));
        chk("a_ack_q", 32'(ack_a), 32'(ea.ack));
        chk("a_err", 32'(err_a), 32'(ea.err));
        chk("a_grant_cycle", 32'(cyc), 32'(ea.cyc));
      end
    end else if (busy_a) begin
      if (qa.size() == 0) flag("a_unexpected_issue");
      else begin
        chk("a_issue_j", 32'(j_a), 32'(qa[0].j));
        chk("a_issue_k", 32'(k_a), 32'(qa[0].k));
      end
    end
  end

  always @(negedge clk) begin
    if (grant_b != 4'b0) begin
      if (qb.size() == 0) flag("b_unexpected_grant");
      else begin
        eb = qb.pop_front();
        $display("txn B grant=%b ack_q=%b err=%b cycle=%0d", grant_b, ack_b, err_b, cyc);
        chk("b_grant", 32'(grant_b), 32'(eb.grant));
        chk("b_ack_q", 32'(ack_b), 32'(eb.ack));
        chk("b_err", 32'(err_b), 32'(eb.err));
        chk("b_grant_cycle", 32'(cyc), 32'(eb.cyc));
      end
    end else if (busy_b) begin
      if (qb.size() == 0) flag("b_unexpected_issue");
      else begin
        chk("b_issue_j", 32'(j_b), 32'(qb[0].j));
        chk("b_issue_k", 32'(k_b), 32'(qb[0].k));
      end
    end
  end

  task automatic push_a(input logic [3:0] g, input logic a, input logic e,
                        input logic [7:0] j, input logic [7:0] k, input int c);
    exp_t x;
    x.grant = g; x.ack = a; x.err = e; x.j = j; x.k = k; x.cyc = c;
    qa.push_back(x);
  endtask

  task automatic push_b(input logic [3:0] g, input logic a, input logic e,
                        input logic [7:0] j, input logic [7:0] k, input int c);
    exp_t x;
    x.grant = g; x.ack = a; x.err = e; x.j = j; x.k = k; x.cyc = c;
    qb.push_back(x);
  endtask

  task automatic req_a(input int r, input logic [1:0] op, input logic [2:0] idx);
    req_valid_a[r]       = 1'b1;
    req_op_a[2*r +: 2]   = op;
    req_idx_a[3*r +: 3]  = idx;
  endtask

  task automatic req_b(input int r, input logic [1:0] op, input logic [2:0] idx);
    req_valid_b[r]       = 1'b1;
    req_op_b[2*r +: 2]   = op;
    req_idx_b[3*r +: 3]  = idx;
  endtask

  // Requesters drop their request in their own grant cycle; returns once everything is quiet.
  task automatic drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (qa.size() == 0 && qb.size() == 0 && !busy_a && !busy_b &&
          req_valid_a == 4'b0 && req_valid_b == 4'b0) return;
      @(negedge clk);
      req_valid_a = req_valid_a & ~grant_a;
      req_valid_b = req_valid_b & ~grant_b;
    end
    flag("drain_timeout");
    qa.delete();
    qb.delete();
    req_valid_a = '0;
    req_valid_b = '0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid_a = '0; req_op_a = '0; req_idx_a = '0;
    req_valid_b = '0; req_op_b = '0; req_idx_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_j", 32'(j_a), 32'h0);
    chk("rst_k", 32'(k_a), 32'h0);
    chk("rst_grant", 32'(grant_a), 32'h0);
    chk("rst_ack_q", 32'(ack_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Out-of-range index on the 6-bit bank, then an in-range set on the same DUT.
    req_b(0, 2'b10, 3'd7);
    push_b(4'b0001, 1'b0, 1'b1, 8'h00, 8'h00, cyc + 2);
    drain(40);
    chk("b_bank_unchanged", 32'(q_b), 32'h00);
    req_b(1, 2'b10, 3'd5);
    push_b(4'b0010, 1'b1, 1'b0, 8'h20, 8'h00, cyc + 2);
    drain(40);
    chk("b_bank_set5", 32'(q_b), 32'h20);

    // Single set with explicit latency and busy check.
    begin
      int c0;
      c0 = cyc;
      req_a(0, 2'b10, 3'd3);
      push_a(4'b0001, 1'b1, 1'b0, 8'h08, 8'h00, c0 + 2);
      repeat (2) @(negedge clk);
      req_valid_a[0] = 1'b0;
      @(negedge clk);
      chk("busy_after_ack", 32'(busy_a), 32'h0);
      chk("jk_idle_after_ack", 32'({j_a, k_a}), 32'h0);
      drain(40);
    end

    // Toggle idx3 twice from requester 1.
    req_a(1, 2'b11, 3'd3);
    push_a(4'b0010, 1'b0, 1'b0, 8'h08, 8'h08, cyc + 2);
    drain(40);
    req_a(1, 2'b11, 3'd3);
    push_a(4'b0010, 1'b1, 1'b0, 8'h08, 8'h08, cyc + 2);
    drain(40);

    // Contention from pointer 0; bank holds 8'h08 here.
    reset_pulse();
    req_a(0, 2'b00, 3'd0);
    req_a(1, 2'b10, 3'd1);
    req_a(2, 2'b01, 3'd3);
    req_a(3, 2'b11, 3'd1);
    push_a(4'b0001, 1'b0, 1'b0, 8'h00, 8'h00, cyc + 2);
    push_a(4'b0010, 1'b1, 1'b0, 8'h02, 8'h00, cyc + 5);
    push_a(4'b0100, 1'b0, 1'b0, 8'h00, 8'h08, cyc + 8);
    push_a(4'b1000, 1'b0, 1'b0, 8'h02, 8'h02, cyc + 11);
    drain(80);
    chk("bank_after_contention", 32'(q_a), 32'h00);

    // Pointer wrapped to 0: requester 0 beats requester 2.
    req_a(2, 2'b10, 3'd6);
    req_a(0, 2'b10, 3'd7);
    push_a(4'b0001, 1'b1, 1'b0, 8'h80, 8'h00, cyc + 2);
    push_a(4'b0100, 1'b1, 1'b0, 8'h40, 8'h00, cyc + 5);
    drain(60);
    chk("bank_after_wrap", 32'(q_a), 32'hC0);

    // Reset during ISSUE: aborted, then re-arbitrated once rst falls.
    begin
      int c0;
      c0 = cyc;
      req_a(1, 2'b10, 3'd2);
      push_a(4'b0010, 1'b1, 1'b0, 8'h04, 8'h00, c0 + 4);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_j", 32'(j_a), 32'h0);
      chk("abort_k", 32'(k_a), 32'h0);
      chk("abort_grant", 32'(grant_a), 32'h0);
      chk("abort_busy", 32'(busy_a), 32'h0);
      rst = 1'b0;
      drain(40);
    end

    // Pointer returns to 0 on reset: requester 1 must beat requester 3.
    reset_pulse();
    req_a(1, 2'b00, 3'd2);
    req_a(3, 2'b01, 3'd2);
    push_a(4'b0010, 1'b1, 1'b0, 8'h00, 8'h00, cyc + 2);
    push_a(4'b1000, 1'b0, 1'b0, 8'h00, 8'h04, cyc + 5);
    drain(60);

    // Set idx5 then a pure read of it.
    req_a(2, 2'b10, 3'd5);
    push_a(4'b0100, 1'b1, 1'b0, 8'h20, 8'h00, cyc + 2);
    drain(40);
    req_a(2, 2'b00, 3'd5);
    push_a(4'b0100, 1'b1, 1'b0, 8'h00, 8'h00, cyc + 2);
    drain(40);
    chk("bank_after_read", 32'(q_a), 32'hE0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
